// File: rtl/top_level.sv
// Hardwired pattern-search engine (program 3) with its own data memory.
// Scans a 32-byte message for a 5-bit pattern and writes three match counts back to memory.

module DataMem (
   input  logic       clk,
   input  logic       i_we,
   input  logic [7:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [7:0] i_raddr,
   output logic [7:0] o_rdata
);

   logic [7:0] core [0:255];

   assign o_rdata = core[i_raddr];

   // No reset on purpose: contents preloaded by the host must survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         core[i_waddr] <= i_wdata;
      end
   end

endmodule

module top_level #(
   parameter int MSG_BYTES = 32,
   parameter int PAT_ADDR  = 32,
   parameter int RES_ADDR  = 33
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic done
);

   typedef enum logic [2:0] {
      INIT,
      SCAN,
      WR0,
      WR1,
      WR2,
      DONE
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(MSG_BYTES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_pat;
   logic [3:0] r_prevLo;
   logic [7:0] r_idx;
   logic [7:0] r_ctb;
   logic [7:0] r_cto;
   logic [7:0] r_cts;
   logic       r_done;

   logic       w_we;
   logic [7:0] w_waddr;
   logic [7:0] w_wdata;
   logic [7:0] w_raddr;
   logic [7:0] w_rdata;
   logic [7:0] w_cross;
   logic [2:0] w_m;
   logic [2:0] w_c;
   logic [7:0] w_stringSum;

   DataMem dm1 (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // Only the SCAN state reads the message; INIT reads the pattern byte, WRx write the results.
   always_comb begin
      w_next  = r_state;
      w_raddr = 8'(PAT_ADDR);
      w_we    = 1'b0;
      w_waddr = 8'(RES_ADDR);
      w_wdata = r_ctb;
      case (r_state)
         INIT: begin
            w_next = SCAN;
         end
         SCAN: begin
            w_raddr = r_idx;
            if (r_idx == LAST_IDX) begin
               w_next = WR0;
            end
         end
         WR0: begin
            w_we    = 1'b1;
            w_waddr = 8'(RES_ADDR);
            w_wdata = r_ctb;
            w_next  = WR1;
         end
         WR1: begin
            w_we    = 1'b1;
            w_waddr = 8'(RES_ADDR + 1);
            w_wdata = r_cto;
            w_next  = WR2;
         end
         WR2: begin
            w_we    = 1'b1;
            w_waddr = 8'(RES_ADDR + 2);
            w_wdata = r_cts;
            w_next  = DONE;
         end
         DONE: begin
            if (req) begin
               w_next = INIT;
            end
         end
         default: begin
            w_next = INIT;
         end
      endcase
   end

   // Cross-byte windows straddle the boundary, so only the previous byte's low nibble matters.
   assign w_cross = {r_prevLo, w_rdata[7:4]};

   always_comb begin
      w_m = 3'd0;
      w_c = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (w_rdata[k +: 5] == r_pat) begin
            w_m = w_m + 3'd1;
         end
      end
      if (r_idx != 8'd0) begin
         for (int k = 0; k < 4; k++) begin
            if (w_cross[k +: 5] == r_pat) begin
               w_c = w_c + 3'd1;
            end
         end
      end
   end

   assign w_stringSum = {5'd0, w_m} + {5'd0, w_c};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pat    <= 5'd0;
         r_prevLo <= 4'd0;
         r_idx    <= 8'd0;
         r_ctb    <= 8'd0;
         r_cto    <= 8'd0;
         r_cts    <= 8'd0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               r_pat    <= w_rdata[7:3];
               r_prevLo <= 4'd0;
               r_idx    <= 8'd0;
               r_ctb    <= 8'd0;
               r_cto    <= 8'd0;
               r_cts    <= 8'd0;
               r_done   <= 1'b0;
            end
            SCAN: begin
               r_prevLo <= w_rdata[3:0];
               r_idx    <= r_idx + 8'd1;
               r_ctb    <= r_ctb + {5'd0, w_m};
               r_cto    <= r_cto + {7'd0, (w_m != 3'd0)};
               r_cts    <= r_cts + w_stringSum;
            end
            DONE: begin
               r_done <= ~req;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign done = r_done;

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for the pattern-search engine.
// Preloads dut.dm1.core hierarchically, runs the engine and compares counts against hand-derived values.

module tb_top_level;

   logic clk;
   logic reset;
   logic req;
   logic done;

   int checkCount = 0;
   int failCount  = 0;
   logic [7:0] expMem [0:32];

   top_level dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case some wait below is ever left unbounded.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Message byte 0 gets firstByte, bytes 1..31 get fillByte; result slots are poisoned.
   task automatic applyStimulus(input logic [7:0] firstByte, input logic [7:0] fillByte, input logic [7:0] patByte);
      for (int a = 0; a < 32; a++) begin
         expMem[a] = (a == 0) ? firstByte : fillByte;
         dut.dm1.core[a] = expMem[a];
      end
      expMem[32] = patByte;
      dut.dm1.core[32] = patByte;
      for (int a = 33; a < 36; a++) begin
         dut.dm1.core[a] = 8'hEE;
      end
   endtask

   // Counts edges until done is seen (sampled on the falling edge), bounded.
   task automatic waitDone(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 60) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic checkResults(input string tag, input int ctb, input int cto, input int cts);
      checkOutput({tag, "_done"}, done, 1);
      checkOutput({tag, "_ctb"}, dut.dm1.core[33], ctb);
      checkOutput({tag, "_cto"}, dut.dm1.core[34], cto);
      checkOutput({tag, "_cts"}, dut.dm1.core[35], cts);
   endtask

   task automatic runTest(input string tag, input logic [7:0] firstByte, input logic [7:0] fillByte,
                          input logic [7:0] patByte, input int ctb, input int cto, input int cts);
      int cycles;
      reset = 1'b1;
      @(negedge clk);
      applyStimulus(firstByte, fillByte, patByte);
      @(negedge clk);
      reset = 1'b0;
      waitDone(cycles);
      checkOutput({tag, "_latency"}, cycles, 37);
      checkResults(tag, ctb, cto, cts);
   endtask

   initial begin
      int cycles;
      int diffs;
      reset = 1'b1;
      req   = 1'b0;
      applyStimulus(8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_keeps_mem", dut.dm1.core[32], 8'h00);
      checkOutput("reset_no_write", dut.dm1.core[33], 8'hEE);

      // All zeros, pattern 00000: every window matches.
      reset = 1'b0;
      waitDone(cycles);
      checkOutput("zeros_latency", cycles, 37);
      checkResults("zeros", 128, 32, 252);
      repeat (5) @(negedge clk);
      checkOutput("zeros_done_held", done, 1);

      runTest("ones_p11111", 8'hFF, 8'hFF, 8'hF8, 128, 32, 252);
      runTest("ones_p00000", 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
      // Low bits of the pattern byte are junk and must be ignored.
      runTest("alt_p10101", 8'h55, 8'h55, 8'hAF, 64, 32, 126);
      runTest("f8_p11111", 8'hF8, 8'h00, 8'hF8, 1, 1, 1);
      // 10000 occurs only straddling bytes 0/1, so it counts in cts alone.
      runTest("f8_p10000", 8'hF8, 8'h00, 8'h80, 0, 0, 1);

      // Reset pulse in the middle of SCAN restarts cleanly.
      reset = 1'b1;
      @(negedge clk);
      applyStimulus(8'h55, 8'h55, 8'hA8);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) begin
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("midreset_busy_done", done, 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_done_low", done, 0);
      reset = 1'b0;
      // req outside DONE must be ignored.
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      waitDone(cycles);
      checkOutput("midreset_latency", cycles + 6, 37);
      checkResults("midreset", 64, 32, 126);

      // Rerun via req with a new pattern.
      runTest("pre_req", 8'hF8, 8'h00, 8'hF8, 1, 1, 1);
      dut.dm1.core[32] = 8'h00;
      expMem[32] = 8'h00;
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      checkOutput("req_done_drop", done, 0);
      waitDone(cycles);
      checkOutput("req_latency", cycles, 37);
      checkResults("req_p00000", 124, 31, 247);
      diffs = 0;
      for (int a = 0; a < 33; a++) begin
         if (dut.dm1.core[a] !== expMem[a]) diffs++;
      end
      checkOutput("req_mem_intact", diffs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
